// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Pixel-clock timing generator. Produces HS/VS/DE, active-pixel X/Y,
//   start-of-frame and end-of-line strobes for three built-in presets
//   (800x600, 1024x768, 1280x720) or a runtime-programmable custom mode.
//   The timing configuration is latched every cycle during reset and on the
//   last cycle of every frame, so mode changes only take effect at a frame
//   boundary. An invalid custom request is refused and flagged.
// Ports:
//   I_pxl_clk            pixel clock
//   I_rst                synchronous reset, active-high
//   I_mode               0=800x600 1=1024x768 2=1280x720 3=custom
//   I_h_*/I_v_*          custom total/sync/back-porch/resolution
//   I_hs_pol/I_vs_pol    custom sync polarity (1 = positive)
//   O_de/O_hs/O_vs       data enable and polarity-applied syncs
//   O_x/O_y              active coordinates (0 outside active video)
//   O_sof/O_eol          first pixel of frame / last pixel of line strobes
//   O_mode_active        mode currently being generated
//   O_cfg_err            sticky: a custom configuration was rejected
module video_timing_gen #(
  parameter int CNT_WIDTH = 12,
  parameter int XY_WIDTH  = 11
) (
  input  logic                 I_pxl_clk,
  input  logic                 I_rst,
  input  logic [1:0]           I_mode,
  input  logic [CNT_WIDTH-1:0] I_h_total,
  input  logic [CNT_WIDTH-1:0] I_h_sync,
  input  logic [CNT_WIDTH-1:0] I_h_bporch,
  input  logic [CNT_WIDTH-1:0] I_h_res,
  input  logic [CNT_WIDTH-1:0] I_v_total,
  input  logic [CNT_WIDTH-1:0] I_v_sync,
  input  logic [CNT_WIDTH-1:0] I_v_bporch,
  input  logic [CNT_WIDTH-1:0] I_v_res,
  input  logic                 I_hs_pol,
  input  logic                 I_vs_pol,
  output logic                 O_de,
  output logic                 O_hs,
  output logic                 O_vs,
  output logic [XY_WIDTH-1:0]  O_x,
  output logic [XY_WIDTH-1:0]  O_y,
  output logic                 O_sof,
  output logic                 O_eol,
  output logic [1:0]           O_mode_active,
  output logic                 O_cfg_err
);

  // One extra bit so sync+bporch+res cannot wrap.
  localparam int SW = CNT_WIDTH + 1;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] h_total;
    logic [CNT_WIDTH-1:0] h_sync;
    logic [CNT_WIDTH-1:0] h_bporch;
    logic [CNT_WIDTH-1:0] h_res;
    logic [CNT_WIDTH-1:0] v_total;
    logic [CNT_WIDTH-1:0] v_sync;
    logic [CNT_WIDTH-1:0] v_bporch;
    logic [CNT_WIDTH-1:0] v_res;
    logic                 hs_pol;
    logic                 vs_pol;
  } timing_t;

  function automatic timing_t preset_cfg(input logic [1:0] mode);
    timing_t t;
    case (mode)
      2'd1: t = '{CNT_WIDTH'(1344), CNT_WIDTH'(136), CNT_WIDTH'(160), CNT_WIDTH'(1024),
                  CNT_WIDTH'(806), CNT_WIDTH'(6), CNT_WIDTH'(29), CNT_WIDTH'(768), 1'b1, 1'b1};
      2'd2: t = '{CNT_WIDTH'(1650), CNT_WIDTH'(40), CNT_WIDTH'(220), CNT_WIDTH'(1280),
                  CNT_WIDTH'(750), CNT_WIDTH'(5), CNT_WIDTH'(20), CNT_WIDTH'(720), 1'b1, 1'b1};
      default: t = '{CNT_WIDTH'(1056), CNT_WIDTH'(128), CNT_WIDTH'(88), CNT_WIDTH'(800),
                     CNT_WIDTH'(628), CNT_WIDTH'(4), CNT_WIDTH'(23), CNT_WIDTH'(600), 1'b1, 1'b1};
    endcase
    return t;
  endfunction

  // A start beyond total is rejected on its own, so start+res only has to
  // fit when start <= total, which the extra bit guarantees.
  function automatic logic cfg_valid(input timing_t t);
    logic [SW-1:0] h_start;
    logic [SW-1:0] v_start;
    logic          nz;
    logic          fit;
    h_start = SW'(t.h_sync) + SW'(t.h_bporch);
    v_start = SW'(t.v_sync) + SW'(t.v_bporch);
    nz  = (t.h_total != {CNT_WIDTH{1'b0}}) && (t.h_res != {CNT_WIDTH{1'b0}}) &&
          (t.v_total != {CNT_WIDTH{1'b0}}) && (t.v_res != {CNT_WIDTH{1'b0}}) &&
          (t.h_sync  != {CNT_WIDTH{1'b0}}) && (t.v_sync != {CNT_WIDTH{1'b0}});
    fit = (h_start <= SW'(t.h_total)) && ((h_start + SW'(t.h_res)) <= SW'(t.h_total)) &&
          (v_start <= SW'(t.v_total)) && ((v_start + SW'(t.v_res)) <= SW'(t.v_total));
    return nz && fit;
  endfunction

  timing_t              cfg_r;
  logic [1:0]           mode_r;
  logic                 cfg_err_r;
  logic [CNT_WIDTH-1:0] h_cnt_r;
  logic [CNT_WIDTH-1:0] v_cnt_r;

  timing_t              req_s;
  logic                 req_ok_s;
  timing_t              nxt_cfg_s;
  logic [1:0]           nxt_mode_s;
  logic                 nxt_err_s;
  logic                 h_wrap_s;
  logic                 v_wrap_s;
  logic                 load_s;
  logic [SW-1:0]        h_pos_s;
  logic [SW-1:0]        v_pos_s;
  logic [SW-1:0]        h_start_s;
  logic [SW-1:0]        v_start_s;
  logic [SW-1:0]        h_end_s;
  logic [SW-1:0]        v_end_s;
  logic                 de_s;
  logic                 hs_act_s;
  logic                 vs_act_s;

  // Configuration requested by the current mode inputs.
  always_comb begin
    req_s = preset_cfg(2'd0);
    if (I_mode == 2'd3) begin
      req_s = '{I_h_total, I_h_sync, I_h_bporch, I_h_res,
                I_v_total, I_v_sync, I_v_bporch, I_v_res, I_hs_pol, I_vs_pol};
    end else begin
      req_s = preset_cfg(I_mode);
    end
  end

  assign req_ok_s = cfg_valid(req_s);

  // Value the config register takes on a load event.
  always_comb begin
    nxt_cfg_s  = cfg_r;
    nxt_mode_s = mode_r;
    nxt_err_s  = cfg_err_r;
    if (req_ok_s) begin
      nxt_cfg_s  = req_s;
      nxt_mode_s = I_mode;
      nxt_err_s  = 1'b0;
    end else if (I_rst) begin
      // Nothing valid to keep while in reset: fall back to 800x600.
      nxt_cfg_s  = preset_cfg(2'd0);
      nxt_mode_s = 2'd0;
      nxt_err_s  = 1'b1;
    end else begin
      nxt_cfg_s  = cfg_r;
      nxt_mode_s = mode_r;
      nxt_err_s  = 1'b1;
    end
  end

  assign h_wrap_s = (h_cnt_r == (cfg_r.h_total - CNT_WIDTH'(1)));
  assign v_wrap_s = (v_cnt_r == (cfg_r.v_total - CNT_WIDTH'(1)));
  assign load_s   = I_rst || (h_wrap_s && v_wrap_s);

  // Config register: reloaded during reset and on the last cycle of a frame.
  always_ff @(posedge I_pxl_clk) begin
    if (load_s) begin
      cfg_r     <= nxt_cfg_s;
      mode_r    <= nxt_mode_s;
      cfg_err_r <= nxt_err_s;
    end
  end

  // Horizontal/vertical position counters.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      h_cnt_r <= {CNT_WIDTH{1'b0}};
      v_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (h_wrap_s) begin
      h_cnt_r <= {CNT_WIDTH{1'b0}};
      v_cnt_r <= v_wrap_s ? {CNT_WIDTH{1'b0}} : (v_cnt_r + CNT_WIDTH'(1));
    end else begin
      h_cnt_r <= h_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign h_pos_s   = SW'(h_cnt_r);
  assign v_pos_s   = SW'(v_cnt_r);
  assign h_start_s = SW'(cfg_r.h_sync) + SW'(cfg_r.h_bporch);
  assign v_start_s = SW'(cfg_r.v_sync) + SW'(cfg_r.v_bporch);
  assign h_end_s   = h_start_s + SW'(cfg_r.h_res);
  assign v_end_s   = v_start_s + SW'(cfg_r.v_res);
  assign hs_act_s  = (h_cnt_r < cfg_r.h_sync);
  assign vs_act_s  = (v_cnt_r < cfg_r.v_sync);
  assign de_s      = (h_pos_s >= h_start_s) && (h_pos_s < h_end_s) &&
                     (v_pos_s >= v_start_s) && (v_pos_s < v_end_s);

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      O_de  <= 1'b0;
      O_hs  <= ~nxt_cfg_s.hs_pol;
      O_vs  <= ~nxt_cfg_s.vs_pol;
      O_x   <= {XY_WIDTH{1'b0}};
      O_y   <= {XY_WIDTH{1'b0}};
      O_sof <= 1'b0;
      O_eol <= 1'b0;
    end else begin
      O_de  <= de_s;
      O_hs  <= ~(hs_act_s ^ cfg_r.hs_pol);
      O_vs  <= ~(vs_act_s ^ cfg_r.vs_pol);
      O_x   <= de_s ? XY_WIDTH'(h_pos_s - h_start_s) : {XY_WIDTH{1'b0}};
      O_y   <= de_s ? XY_WIDTH'(v_pos_s - v_start_s) : {XY_WIDTH{1'b0}};
      O_sof <= de_s && (h_pos_s == h_start_s) && (v_pos_s == v_start_s);
      O_eol <= de_s && (h_pos_s == (h_end_s - SW'(1)));
    end
  end

  assign O_mode_active = mode_r;
  assign O_cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  logic        I_pxl_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [1:0]  I_mode = 2'd2;
  logic [11:0] I_h_total = 12'd0, I_h_sync = 12'd0, I_h_bporch = 12'd0, I_h_res = 12'd0;
  logic [11:0] I_v_total = 12'd0, I_v_sync = 12'd0, I_v_bporch = 12'd0, I_v_res = 12'd0;
  logic        I_hs_pol = 1'b1, I_vs_pol = 1'b1;
  logic        O_de, O_hs, O_vs, O_sof, O_eol, O_cfg_err;
  logic [10:0] O_x, O_y;
  logic [1:0]  O_mode_active;

  int vectors = 0;
  int miscompares = 0;

  video_timing_gen #(.CNT_WIDTH(12), .XY_WIDTH(11)) dut (
    .I_pxl_clk(I_pxl_clk), .I_rst(I_rst), .I_mode(I_mode),
    .I_h_total(I_h_total), .I_h_sync(I_h_sync), .I_h_bporch(I_h_bporch), .I_h_res(I_h_res),
    .I_v_total(I_v_total), .I_v_sync(I_v_sync), .I_v_bporch(I_v_bporch), .I_v_res(I_v_res),
    .I_hs_pol(I_hs_pol), .I_vs_pol(I_vs_pol),
    .O_de(O_de), .O_hs(O_hs), .O_vs(O_vs), .O_x(O_x), .O_y(O_y),
    .O_sof(O_sof), .O_eol(O_eol), .O_mode_active(O_mode_active), .O_cfg_err(O_cfg_err)
  );

  always #5 I_pxl_clk = ~I_pxl_clk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int ht, hsy, hbp, hr, vt, vsy, vbp, vr;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic de, hs, vs, sof, eol;
    logic [10:0] x, y;
    logic [1:0] mode;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  cfg_t mc;
  int   mh = 0, mv = 0;
  bit [1:0] mm = 2'd0;
  bit   me = 1'b0;

  function automatic cfg_t preset(input int m);
    cfg_t c;
    case (m)
      1: c = '{1344, 136, 160, 1024, 806, 6, 29, 768, 1'b1, 1'b1};
      2: c = '{1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1};
      default: c = '{1056, 128, 88, 800, 628, 4, 23, 600, 1'b1, 1'b1};
    endcase
    return c;
  endfunction

  function automatic cfg_t requested();
    cfg_t c;
    if (I_mode == 2'd3)
      c = '{int'(I_h_total), int'(I_h_sync), int'(I_h_bporch), int'(I_h_res),
            int'(I_v_total), int'(I_v_sync), int'(I_v_bporch), int'(I_v_res), I_hs_pol, I_vs_pol};
    else
      c = preset(int'(I_mode));
    return c;
  endfunction

  function automatic bit cfg_ok(input cfg_t c);
    return (c.ht != 0) && (c.hr != 0) && (c.vt != 0) && (c.vr != 0) &&
           (c.hsy != 0) && (c.vsy != 0) &&
           (c.hsy + c.hbp + c.hr <= c.ht) && (c.vsy + c.vbp + c.vr <= c.vt);
  endfunction

  // Model: on each falling edge predict what the next rising edge presents.
  initial begin
    cfg_t req;
    exp_t e;
    int   xi, yi;
    bit   de;
    mc = preset(0);
    forever begin
      @(negedge I_pxl_clk);
      req = requested();
      e = '0;
      if (I_rst) begin
        if (cfg_ok(req)) begin
          mc = req; mm = I_mode; me = 1'b0;
        end else begin
          mc = preset(0); mm = 2'd0; me = 1'b1;
        end
        mh = 0; mv = 0;
        e.hs = !mc.hp;
        e.vs = !mc.vp;
      end else begin
        xi = mh - (mc.hsy + mc.hbp);
        yi = mv - (mc.vsy + mc.vbp);
        de = (xi >= 0) && (xi < mc.hr) && (yi >= 0) && (yi < mc.vr);
        e.de  = de;
        e.hs  = (mh < mc.hsy) ? mc.hp : !mc.hp;
        e.vs  = (mv < mc.vsy) ? mc.vp : !mc.vp;
        e.x   = de ? 11'(xi) : 11'd0;
        e.y   = de ? 11'(yi) : 11'd0;
        e.sof = de && (xi == 0) && (yi == 0);
        e.eol = de && (xi == mc.hr - 1);
        if (mh == mc.ht - 1 && mv == mc.vt - 1) begin
          if (cfg_ok(req)) begin
            mc = req; mm = I_mode; me = 1'b0;
          end else begin
            me = 1'b1;
          end
          mh = 0; mv = 0;
        end else if (mh == mc.ht - 1) begin
          mh = 0; mv = mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
      e.mode = mm;
      e.err  = me;
      exp_q.push_back(e);
    end
  end

  // Scoreboard: pop one prediction per rising edge and compare.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge I_pxl_clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {O_de, O_hs, O_vs, O_sof, O_eol, O_x, O_y, O_mode_active, O_cfg_err};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got de%0b hs%0b vs%0b sof%0b eol%0b x%0d y%0d m%0d err%0b, expected de%0b hs%0b vs%0b sof%0b eol%0b x%0d y%0d m%0d err%0b",
                   $time, got.de, got.hs, got.vs, got.sof, got.eol, got.x, got.y, got.mode, got.err,
                   e.de, e.hs, e.vs, e.sof, e.eol, e.x, e.y, e.mode, e.err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_edge();
    @(posedge I_pxl_clk);
    #1;
  endtask

  task automatic set_custom(input int ht, hs, hb, hr, vt, vs, vb, vr, input bit hp, vp);
    I_h_total = 12'(ht); I_h_sync = 12'(hs); I_h_bporch = 12'(hb); I_h_res = 12'(hr);
    I_v_total = 12'(vt); I_v_sync = 12'(vs); I_v_bporch = 12'(vb); I_v_res = 12'(vr);
    I_hs_pol = hp; I_vs_pol = vp;
  endtask

  task automatic test_reset();
    I_rst = 1'b1; I_mode = 2'd2;
    repeat (3) wait_edge();
    vectors++;
    if ({O_de, O_hs, O_vs, O_sof, O_eol} !== 5'b00000) begin
      miscompares++; $display("FAIL reset_levels: got %b, expected 00000", {O_de, O_hs, O_vs, O_sof, O_eol});
    end
    vectors++;
    if ({O_mode_active, O_cfg_err} !== {2'd2, 1'b0}) begin
      miscompares++; $display("FAIL reset_mode2: got mode %0d err %0b, expected 2/0", O_mode_active, O_cfg_err);
    end
    // Invalid custom while in reset falls back to mode 0 with the error flag.
    I_mode = 2'd3;
    set_custom(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    wait_edge();
    vectors++;
    if ({O_mode_active, O_cfg_err, O_hs, O_vs} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL reset_reject: got mode %0d err %0b hs %0b vs %0b, expected 0/1/0/0",
                              O_mode_active, O_cfg_err, O_hs, O_vs);
    end
    // Valid negative-polarity custom: idle level of the syncs is high.
    set_custom(100, 10, 10, 50, 20, 2, 2, 10, 1'b0, 1'b0);
    wait_edge();
    vectors++;
    if ({O_mode_active, O_cfg_err, O_hs, O_vs} !== {2'd3, 1'b0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL reset_custom: got mode %0d err %0b hs %0b vs %0b, expected 3/0/1/1",
                              O_mode_active, O_cfg_err, O_hs, O_vs);
    end
  endtask

  task automatic test_mode2_start();
    int sof_e = -1;
    int hs_hi = 0;
    I_mode = 2'd2; I_rst = 1'b1;
    wait_edge();
    I_rst = 1'b0;
    for (int e = 0; e < 45000; e++) begin
      wait_edge();
      if (e < 1650 && O_hs === 1'b1) hs_hi++;
      if (O_sof === 1'b1) begin
        sof_e = e;
        break;
      end
    end
    vectors++;
    if (sof_e !== 41510) begin
      miscompares++; $display("FAIL mode2_sof_edge: got %0d, expected 41510", sof_e);
    end
    vectors++;
    if (hs_hi !== 40) begin
      miscompares++; $display("FAIL mode2_hs_width: got %0d, expected 40", hs_hi);
    end
  endtask

  task automatic test_custom();
    int hs_lo[2], vs_lo[2], de_n[2], eol_n[2];
    int sof_e = -1;
    int bad_x = 0;
    int fr;
    for (int i = 0; i < 2; i++) begin hs_lo[i] = 0; vs_lo[i] = 0; de_n[i] = 0; eol_n[i] = 0; end
    I_mode = 2'd3;
    set_custom(100, 10, 10, 50, 20, 2, 2, 10, 1'b0, 1'b0);
    I_rst = 1'b1;
    wait_edge();
    I_rst = 1'b0;
    for (int e = 0; e < 4000; e++) begin
      wait_edge();
      fr = e / 2000;
      if (O_hs === 1'b0) hs_lo[fr]++;
      if (O_vs === 1'b0) vs_lo[fr]++;
      if (O_de === 1'b1) de_n[fr]++;
      if (O_eol === 1'b1) begin
        eol_n[fr]++;
        if (O_x !== 11'd49) bad_x++;
      end
      if (sof_e < 0 && O_sof === 1'b1) sof_e = e;
    end
    for (int f = 0; f < 2; f++) begin
      vectors++;
      if ({hs_lo[f], vs_lo[f], de_n[f], eol_n[f]} !== {32'd200, 32'd200, 32'd500, 32'd10}) begin
        miscompares++;
        $display("FAIL custom_counts frame %0d: got hs_lo %0d vs_lo %0d de %0d eol %0d, expected 200/200/500/10",
                 f, hs_lo[f], vs_lo[f], de_n[f], eol_n[f]);
      end
    end
    vectors++;
    if (sof_e !== 420) begin
      miscompares++; $display("FAIL custom_sof_edge: got %0d, expected 420", sof_e);
    end
    vectors++;
    if (bad_x !== 0) begin
      miscompares++; $display("FAIL custom_eol_x: got %0d eol pulses off x=49, expected 0", bad_x);
    end
  endtask

  // Frame is aligned here: the next edge presents position 0.
  task automatic test_reject();
    int err_k = -1;
    int de_n = 0;
    set_custom(100, 10, 10, 200, 20, 2, 2, 10, 1'b0, 1'b0);
    for (int k = 0; k < 4000; k++) begin
      wait_edge();
      if (err_k < 0 && O_cfg_err === 1'b1) err_k = k;
      if (k >= 2000 && O_de === 1'b1) de_n++;
    end
    vectors++;
    if (err_k !== 1999) begin
      miscompares++; $display("FAIL reject_err_edge: got %0d, expected 1999", err_k);
    end
    vectors++;
    if ({de_n, 30'd0, O_mode_active} !== {32'd500, 30'd0, 2'd3}) begin
      miscompares++; $display("FAIL reject_keeps_timing: got de %0d mode %0d, expected 500/3", de_n, O_mode_active);
    end
  endtask

  task automatic test_exact_fit();
    int de1 = 0, de2 = 0, eol_end = 0;
    int first_eol_x = -1;
    set_custom(100, 10, 10, 80, 20, 2, 2, 10, 1'b0, 1'b0);
    for (int k = 0; k < 6000; k++) begin
      wait_edge();
      if (k == 1999) begin
        vectors++;
        if (O_cfg_err !== 1'b0) begin
          miscompares++; $display("FAIL exact_fit_accept: got err %0b, expected 0", O_cfg_err);
        end
      end
      if (k == 2500) I_h_res = 12'd81;
      if (k >= 2000 && k < 4000) begin
        if (O_de === 1'b1) de1++;
        if (O_eol === 1'b1 && ((k - 2000) % 100) == 99) eol_end++;
        if (first_eol_x < 0 && O_eol === 1'b1) first_eol_x = int'(O_x);
      end
      if (k == 3999) begin
        vectors++;
        if (O_cfg_err !== 1'b1) begin
          miscompares++; $display("FAIL one_over_reject: got err %0b, expected 1", O_cfg_err);
        end
      end
      if (k >= 4000 && O_de === 1'b1) de2++;
    end
    vectors++;
    if ({de1, eol_end, first_eol_x} !== {32'd800, 32'd10, 32'd79}) begin
      miscompares++; $display("FAIL exact_fit_line: got de %0d eol_at_end %0d eol_x %0d, expected 800/10/79",
                              de1, eol_end, first_eol_x);
    end
    vectors++;
    if (de2 !== 800) begin
      miscompares++; $display("FAIL one_over_keeps: got de %0d, expected 800", de2);
    end
  endtask

  task automatic test_mode_switch();
    int bnd = -1;
    int sof_k = -1;
    for (int k = 0; k < 35000; k++) begin
      wait_edge();
      if (k == 700) I_mode = 2'd0;
      if (k == 1000) begin
        vectors++;
        if (O_mode_active !== 2'd3) begin
          miscompares++; $display("FAIL switch_midframe: got mode %0d, expected 3", O_mode_active);
        end
      end
      if (bnd < 0 && O_mode_active === 2'd0) bnd = k;
      if (bnd >= 0 && O_sof === 1'b1) begin
        sof_k = k;
        break;
      end
    end
    vectors++;
    if (bnd !== 1999) begin
      miscompares++; $display("FAIL switch_boundary: got %0d, expected 1999", bnd);
    end
    // The edge after the boundary presents position 0 of the new frame.
    vectors++;
    if (sof_k - bnd - 1 !== 28728) begin
      miscompares++; $display("FAIL switch_sof_delay: got %0d, expected 28728", sof_k - bnd - 1);
    end
    vectors++;
    if (O_cfg_err !== 1'b0) begin
      miscompares++; $display("FAIL switch_err_clear: got %0b, expected 0", O_cfg_err);
    end
  endtask

  task automatic test_reset_midline();
    int hs_hi = 0;
    int de_n = 0;
    I_rst = 1'b1;
    wait_edge();
    vectors++;
    if ({O_de, O_hs, O_x, O_y, O_sof} !== {1'b0, 1'b0, 11'd0, 11'd0, 1'b0}) begin
      miscompares++; $display("FAIL midline_reset: got de %0b hs %0b x %0d y %0d sof %0b, expected all 0",
                              O_de, O_hs, O_x, O_y, O_sof);
    end
    I_rst = 1'b0;
    for (int e = 0; e < 1056; e++) begin
      wait_edge();
      if (O_hs === 1'b1) hs_hi++;
      if (O_de === 1'b1) de_n++;
    end
    vectors++;
    if ({hs_hi, de_n} !== {32'd128, 32'd0}) begin
      miscompares++; $display("FAIL midline_restart: got hs_hi %0d de %0d, expected 128/0", hs_hi, de_n);
    end
  endtask

  initial begin
    test_reset();
    test_mode2_start();
    test_custom();
    test_reject();
    test_exact_fit();
    test_mode_switch();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
